// File: rtl/px_fb_pkg.sv
// px_fb_pkg: default frame-buffer geometry and the responder FSM encoding
package px_fb_pkg;
  localparam int PX_ADDR_W = 16;
  localparam int PX_DATA_W = 24;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2,
    DROP    = 2'd3
  } px_state_t;
endpackage

// File: rtl/px_fb_ram.sv
// px_fb_ram: single-port frame-buffer RAM, synchronous read-first with registered output
module px_fb_ram
  import px_fb_pkg::*;
#(
  parameter int ADDR_W = PX_ADDR_W,
  parameter int DATA_W = PX_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/px_fb_responder.sv
// px_fb_responder: pixel request/response front end over one frame-buffer RAM port.
// Define PX_FB_SCAN_EN to add the display scan-out port, which has priority over pixel requests.
module px_fb_responder
  import px_fb_pkg::*;
#(
  parameter int ADDR_W = PX_ADDR_W,
  parameter int DATA_W = PX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              px_request,
  input  logic              px_write,
  input  logic [ADDR_W-1:0] px_address,
  input  logic [DATA_W-1:0] px_write_data,
  output logic              px_ready,
  output logic [DATA_W-1:0] px_read_data,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_address,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data
);
  px_state_t state, state_nxt;
  logic scan_grant, accept, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
`ifdef PX_FB_SCAN_EN
  assign scan_grant = scan_req;
`else
  logic unused_scan;
  assign scan_grant = 1'b0;
  assign unused_scan = ^{scan_req, scan_address};
`endif
  // Pixel requests only touch the RAM in IDLE, so scan-out owns the port in every other state
  assign accept = state == IDLE && px_request && !scan_grant;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE    ? (accept ? (px_write ? RESP : RD_WAIT) : IDLE) :
                state == RD_WAIT ? RESP :
                state == RESP    ? DROP :
                px_request       ? DROP : IDLE;
  end
  always_comb begin
    px_ready = state == RESP;
    ram_we   = accept && px_write;
    ram_addr = scan_grant ? scan_address : px_address;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) px_read_data <= '0;
    else if (state == RD_WAIT) px_read_data <= ram_rdata;
  end
`ifdef PX_FB_SCAN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scan_valid <= 1'b0;
    else scan_valid <= scan_grant;
  end
  assign scan_data = scan_valid ? ram_rdata : '0;
`else
  assign scan_valid = 1'b0;
  assign scan_data  = '0;
`endif
  px_fb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (px_write_data),
    .rdata (ram_rdata)
  );
endmodule

// File: doc/px_fb_responder.md
PX_FB_RESPONDER -- requirements
Module: px_fb_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, pixel address width (256x256 frame buffer).
REQ-002 SHALL have parameter DATA_W, default 24, pixel width (RGB888).
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port px_request  input  1  active-high request, held until px_ready seen.
REQ-006 SHALL have port px_write  input  1  1 => write, 0 => read; valid while px_request high.
REQ-007 SHALL have port px_address  input  ADDR_W  pixel address.
REQ-008 SHALL have port px_write_data  input  DATA_W  pixel to write.
REQ-009 SHALL have port px_ready  output  1  one-cycle pulse: write done or read data valid.
REQ-010 SHALL have port px_read_data  output  DATA_W  registered read result.
REQ-011 SHALL have port scan_req  input  1  display scan-out read request, one address per cycle.
REQ-012 SHALL have port scan_address  input  ADDR_W  scan-out address.
REQ-013 SHALL have port scan_valid  output  1  scan_data valid.
REQ-014 SHALL have port scan_data  output  DATA_W  scan-out pixel.

Function
REQ-015 SHALL store pixels in one single-port synchronous RAM of 2**ADDR_W x DATA_W; exactly one RAM access per cycle.
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, RESP, DROP.
REQ-017 IDLE: px_request=1 and RAM port free -> accept; write -> RAM written this cycle, go RESP; read -> RAM read issued, go RD_WAIT.
REQ-018 RD_WAIT: capture RAM output into px_read_data, go RESP.
REQ-019 RESP: px_ready=1 for exactly this cycle, go DROP.
REQ-020 DROP: remain until px_request=0, then IDLE; a request held high after px_ready SHALL NOT be re-executed.
REQ-021 Latency from accept edge: write px_ready at +1 cycle, read px_ready at +2 cycles with px_read_data valid in the same cycle.
REQ-022 px_read_data SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-023 Scan-out SHALL have priority: scan_req=1 in IDLE blocks px acceptance that cycle; request waits, unaltered.
REQ-024 scan_req in cycle N SHALL give scan_valid=1 and scan_data=RAM[scan_address] in cycle N+1; back-to-back scan_req SHALL stream one pixel per cycle.
REQ-025 scan_req during RD_WAIT/RESP/DROP SHALL be served (px access already complete in RAM).
REQ-026 Write and scan to the same address: if write accepted in cycle N, scan in N+1 or later SHALL return new data.
REQ-027 Addresses SHALL be used unmodified; no wrap or bounds logic beyond ADDR_W truncation.

Reset
REQ-028 On rst: state IDLE, px_ready=0, px_read_data=0, scan_valid=0, scan_data=0, asynchronously.
REQ-029 rst mid-transaction SHALL abort it with no px_ready; a write accepted before rst remains in RAM; RAM contents SHALL NOT be cleared.

Configuration
REQ-030 Macro PX_FB_SCAN_EN defined: scan port, priority arbitration and scan outputs as above.
REQ-031 PX_FB_SCAN_EN undefined: scan_req/scan_address ignored, scan_valid and scan_data tied 0, px requests never stalled.

Structure
REQ-032 Package px_fb_pkg SHALL hold default ADDR_W/DATA_W constants and FSM state encoding.
REQ-033 RAM SHALL be sub-module px_fb_ram (single-port, sync read, registered output, write-enable); FSM/arbiter in px_fb_responder.

Verification
REQ-034 Write 0x00AA55 to 0x0102 then read 0x0102 -> write px_ready at +1, read px_ready at +2 with px_read_data=0x00AA55.
REQ-035 Hold px_request high 5 cycles after px_ready -> exactly one px_ready, one RAM access; next request accepted after drop.
REQ-036 scan_req held high 4 cycles while px read pending -> px accepted cycle after scan_req falls; 4 consecutive scan_valid pulses.
REQ-037 Write 0x123456 to 0xFFFF, scan 0xFFFF next cycle -> scan_data=0x123456.
REQ-038 Assert rst during RD_WAIT -> no px_ready, px_read_data=0; prior written pixels still readable after rst.
REQ-039 Build without PX_FB_SCAN_EN, scan_req=1 continuously -> px latency unchanged, scan_valid stays 0.
